// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param.
// master drives requests, slave is the FIFO side.
interface fifo_sync_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, rd_valid,
        input  wr_ack, overflow, underflow,
        input  full, empty,
        input  almostfull, almostempty,
        input  count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, rd_valid,
        output wr_ack, overflow, underflow,
        output full, empty,
        output almostfull, almostempty,
        output count
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO, any depth >= 2, with thresholds,
// occupancy output and optional first-word fall-through.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit FWFT       = 1'b0,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input logic              clk,
    input logic              rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ?
                        $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: FIFO_DEPTH < 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH out of range");
    end

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.rd_en && !w_empty;
    // a read at full frees the slot the write lands in
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_ack <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_acc;
            r_ovf    <= bus.wr_en && !w_wr_acc;
            r_udf    <= bus.rd_en && !w_rd_acc;
            // explicit wrap keeps non-power-of-two depths legal
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ?
                            '0 : r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ?
                            '0 : r_rd_ptr + PW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    if (FWFT == 1'b0) begin : g_reg
        logic [FIFO_WIDTH-1:0] r_dout;
        logic                  r_rv;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout <= '0;
                r_rv   <= 1'b0;
            end else begin
                r_rv <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
        end

        assign bus.data_out = r_dout;
        assign bus.rd_valid = r_rv;
    end else begin : g_fwft
        assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        assign bus.rd_valid = !w_empty;
    end

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_udf;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count >= CW'(AF_THRESH));
    assign bus.almostempty = (r_count <= CW'(AE_THRESH));
    assign bus.count       = r_count;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench: three FIFO configs share one stimulus stream and
// are checked every cycle against a queue-based model.
module tb_fifo_sync_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] din = '0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b0 ();
    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b1 ();
    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) b2 ();

    assign b0.wr_en = wr_en;
    assign b0.rd_en = rd_en;
    assign b0.data_in = din;
    assign b1.wr_en = wr_en;
    assign b1.rd_en = rd_en;
    assign b1.data_in = din;
    assign b2.wr_en = wr_en;
    assign b2.rd_en = rd_en;
    assign b2.data_in = din;

    fifo_sync_param #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)
    ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    fifo_sync_param #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    fifo_sync_param #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(1'b0),
        .AF_THRESH(5), .AE_THRESH(2)
    ) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    // model configuration per instance
    int md  [3] = '{8, 8, 6};
    bit mfw [3] = '{1'b0, 1'b1, 1'b0};
    int maf [3] = '{6, 6, 5};
    int mae [3] = '{1, 1, 2};

    logic [15:0] mq [3][$];
    bit [15:0]   m_dout [3];
    bit          m_rv  [3];
    bit          m_ack [3];
    bit          m_ovf [3];
    bit          m_udf [3];

    // DUT outputs gathered for indexed comparison
    logic [15:0] d_out [3];
    logic [3:0]  d_cnt [3];
    logic [7:0]  d_flg [3];

    assign d_out[0] = b0.data_out;
    assign d_out[1] = b1.data_out;
    assign d_out[2] = b2.data_out;
    assign d_cnt[0] = 4'(b0.count);
    assign d_cnt[1] = 4'(b1.count);
    assign d_cnt[2] = 4'(b2.count);
    assign d_flg[0] = {b0.rd_valid, b0.wr_ack,
                       b0.overflow, b0.underflow,
                       b0.full, b0.empty,
                       b0.almostfull, b0.almostempty};
    assign d_flg[1] = {b1.rd_valid, b1.wr_ack,
                       b1.overflow, b1.underflow,
                       b1.full, b1.empty,
                       b1.almostfull, b1.almostempty};
    assign d_flg[2] = {b2.rd_valid, b2.wr_ack,
                       b2.overflow, b2.underflow,
                       b2.full, b2.empty,
                       b2.almostfull, b2.almostempty};

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // behavioural model: plain queue semantics
    always @(posedge clk or negedge rst_n) begin
        int n;
        bit racc;
        bit wacc;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                m_dout[k] = '0;
                m_rv[k]   = 1'b0;
                m_ack[k]  = 1'b0;
                m_ovf[k]  = 1'b0;
                m_udf[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                n    = mq[k].size();
                racc = rd_en && (n != 0);
                wacc = wr_en && ((n != md[k]) || racc);
                m_ack[k] = wacc;
                m_ovf[k] = wr_en && !wacc;
                m_udf[k] = rd_en && !racc;
                if (!mfw[k]) m_rv[k] = racc;
                if (racc) begin
                    if (!mfw[k]) m_dout[k] = mq[k][0];
                    void'(mq[k].pop_front());
                end
                if (wacc) mq[k].push_back(din);
            end
        end
    end

    // one compare process, every falling edge
    always @(negedge clk) begin
        int n;
        logic [15:0] e_out;
        logic [7:0]  e_flg;
        for (int k = 0; k < 3; k++) begin
            n = mq[k].size();
            if (mfw[k]) begin
                e_out = (n != 0) ? mq[k][0] : 16'h0;
            end else begin
                e_out = m_dout[k];
            end
            e_flg = {mfw[k] ? (n != 0) : m_rv[k],
                     m_ack[k], m_ovf[k], m_udf[k],
                     n == md[k], n == 0,
                     n >= maf[k], n <= mae[k]};
            chk($sformatf("u%0d.count", k),
                32'(d_cnt[k]), 32'(n));
            chk($sformatf("u%0d.data_out", k),
                32'(d_out[k]), 32'(e_out));
            chk($sformatf("u%0d.flags", k),
                32'(d_flg[k]), 32'(e_flg));
        end
    end

    task automatic cyc(input bit w, input bit r,
                       input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.count", 32'(b0.count), 0);
        chk("rst.empty", 32'(b0.empty), 1);
        chk("rst.almostempty", 32'(b0.almostempty), 1);
        chk("rst.full", 32'(b0.full), 0);
        chk("rst.rd_valid", 32'(b0.rd_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            chk("t1.wr_ack", 32'(b0.wr_ack), 1);
            chk("t1.count", 32'(b0.count), 32'(i));
            chk("t1.almostfull", 32'(b0.almostfull),
                32'(i >= 6));
            chk("t1.full", 32'(b0.full), 32'(i == 8));
        end
        cyc(1'b1, 1'b0, 16'h0009);
        chk("t1.overflow", 32'(b0.overflow), 1);
        chk("t1.ovf_ack", 32'(b0.wr_ack), 0);
        chk("t1.ovf_count", 32'(b0.count), 8);

        // drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk("t2.data_out", 32'(b0.data_out), 32'(i));
            chk("t2.rd_valid", 32'(b0.rd_valid), 1);
        end
        cyc(1'b0, 1'b1, 16'h0);
        chk("t2.underflow", 32'(b0.underflow), 1);
        chk("t2.udf_valid", 32'(b0.rd_valid), 0);
        chk("t2.hold", 32'(b0.data_out), 32'h0008);
        chk("t2.empty", 32'(b0.empty), 1);

        // simultaneous read+write at full
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0010 + i));
        end
        cyc(1'b1, 1'b1, 16'hAAAA);
        chk("t3.wr_ack", 32'(b0.wr_ack), 1);
        chk("t3.overflow", 32'(b0.overflow), 0);
        chk("t3.count", 32'(b0.count), 8);
        chk("t3.oldest", 32'(b0.data_out), 32'h0011);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
        end
        chk("t3.last", 32'(b0.data_out), 32'hAAAA);

        // simultaneous read+write at empty
        cyc(1'b1, 1'b1, 16'h5555);
        chk("t4.underflow", 32'(b0.underflow), 1);
        chk("t4.wr_ack", 32'(b0.wr_ack), 1);
        chk("t4.count", 32'(b0.count), 1);
        cyc(1'b0, 1'b1, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);

        // fall-through instance
        cyc(1'b1, 1'b0, 16'h1234);
        chk("t4.fwft_data", 32'(b1.data_out), 32'h1234);
        chk("t4.fwft_valid", 32'(b1.rd_valid), 1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("t4.fwft_empty", 32'(b1.empty), 1);
        chk("t4.fwft_zero", 32'(b1.data_out), 0);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                16'($urandom));
            chk("t5.u2_max", 32'(b2.count <= 3'd6), 1);
        end

        // steer depth-6 instance to 4 entries
        for (int i = 0; i < 20; i++) begin
            n = mq[2].size();
            if (n == 4) break;
            cyc(n < 4, n > 4, 16'($urandom));
        end
        chk("t5.steer", 32'(b2.count), 4);
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;

        // reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rst_count", 32'(b2.count), 0);
        chk("t5.rst_empty", 32'(b2.empty), 1);
        chk("t5.rst_ack", 32'(b2.wr_ack), 0);
        chk("t5.rst_ovf", 32'(b2.overflow), 0);
        chk("t5.rst_udf", 32'(b2.underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
